// File: rtl/muldiv_pkg.sv
// Shared types and constants for the RV32M multiply/divide sequencer.
package muldiv_pkg;

    localparam int MULDIV_XLEN  = 32;
    localparam int MULDIV_ITERS = 32;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b1000;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } muldiv_op_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_ITER,
        S_FIX
    } muldiv_state_t;

    function automatic logic [MULDIV_XLEN-1:0] mag(
        input logic [MULDIV_XLEN-1:0] v,
        input logic                   neg
    );
        return neg ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/response bundle between the execute stage and muldiv_seq.
interface muldiv_if;
    import muldiv_pkg::*;

    logic                   start;
    logic [2:0]             op;
    logic [MULDIV_XLEN-1:0] a;
    logic [MULDIV_XLEN-1:0] b;
    logic                   busy;
    logic                   done;
    logic [MULDIV_XLEN-1:0] result;

    modport master (
        output start, op, a, b,
        input  busy, done, result
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, result
    );

endinterface

// File: rtl/muldiv_seq.sv
// RV32M multi-cycle sequencer driving the shared ALU with ADD/SUB steps.
// Divide support is built only when MULDIV_DIV_EN is defined.
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int ITERS = MULDIV_ITERS
) (
    input  logic            CLK,
    input  logic            RST,
    muldiv_if.slave         bus,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [3:0]      alu_fun,
    input  logic [XLEN-1:0] alu_result
);

    muldiv_state_t   state;
    muldiv_op_t      op_q;
    logic [XLEN-1:0] mcand;
    logic [XLEN-1:0] acc_hi;
    logic [XLEN-1:0] acc_lo;
    logic [4:0]      cnt;
    logic            neg_p;
    logic            neg_r;

    logic is_div;
    logic a_neg;
    logic b_neg;
    logic carry;

    assign is_div = op_q[2];
    assign a_neg  = (op_q inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM})
                    && acc_lo[XLEN-1];
    assign b_neg  = (op_q inside {OP_MULH, OP_DIV, OP_REM})
                    && mcand[XLEN-1];
    assign carry  = alu_result < acc_hi;

`ifdef MULDIV_DIV_EN
    logic [XLEN-1:0] rem_s;
    logic            ovf;
    assign rem_s = {acc_hi[XLEN-2:0], acc_lo[XLEN-1]};
    assign ovf   = (op_q == OP_DIV || op_q == OP_REM)
                   && acc_lo == {1'b1, {(XLEN-1){1'b0}}}
                   && mcand == '1;
`endif

    always_comb begin
        alu_a   = '0;
        alu_b   = '0;
        alu_fun = ALU_ADD;
        if (state == S_ITER) begin
`ifdef MULDIV_DIV_EN
            if (is_div) begin
                alu_a   = rem_s;
                alu_b   = mcand;
                alu_fun = ALU_SUB;
            end else
`endif
            begin
                alu_a = acc_hi;
                alu_b = acc_lo[0] ? mcand : '0;
            end
        end
    end

    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quot;
    logic [XLEN-1:0]   remv;
    logic [XLEN-1:0]   word;

    always_comb begin
        prod = {acc_hi, acc_lo};
        if (neg_p) prod = ~prod + 1'b1;
        quot = neg_p ? (~acc_lo + 1'b1) : acc_lo;
        remv = neg_r ? (~acc_hi + 1'b1) : acc_hi;
        unique case (op_q)
            OP_MUL:                       word = prod[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: word = prod[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              word = quot;
            default:                      word = remv;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= S_IDLE;
            op_q       <= OP_MUL;
            mcand      <= '0;
            acc_hi     <= '0;
            acc_lo     <= '0;
            cnt        <= '0;
            neg_p      <= 1'b0;
            neg_r      <= 1'b0;
            bus.busy   <= 1'b0;
            bus.done   <= 1'b0;
            bus.result <= '0;
        end else begin
            bus.done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    bus.busy <= bus.start;
                    if (bus.start) begin
                        op_q   <= muldiv_op_t'(bus.op);
                        acc_lo <= bus.a;
                        mcand  <= bus.b;
                        state  <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    acc_hi <= '0;
                    acc_lo <= mag(acc_lo, a_neg);
                    mcand  <= mag(mcand, b_neg);
                    neg_p  <= a_neg ^ b_neg;
                    neg_r  <= a_neg;
                    cnt    <= 5'(ITERS - 1);
                    state  <= S_ITER;
                    if (is_div) begin
`ifdef MULDIV_DIV_EN
                        // Special cases bypass ITER with final words preloaded
                        if (mcand == '0) begin
                            acc_lo <= '1;
                            acc_hi <= acc_lo;
                            neg_p  <= 1'b0;
                            neg_r  <= 1'b0;
                            state  <= S_FIX;
                        end else if (ovf) begin
                            acc_lo <= {1'b1, {(XLEN-1){1'b0}}};
                            neg_p  <= 1'b0;
                            neg_r  <= 1'b0;
                            state  <= S_FIX;
                        end
`else
                        acc_lo <= '0;
                        neg_p  <= 1'b0;
                        neg_r  <= 1'b0;
                        state  <= S_FIX;
`endif
                    end
                end
                S_ITER: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == '0) state <= S_FIX;
`ifdef MULDIV_DIV_EN
                    if (is_div) begin
                        if (acc_hi[XLEN-1] || rem_s >= mcand) begin
                            acc_hi <= alu_result;
                            acc_lo <= {acc_lo[XLEN-2:0], 1'b1};
                        end else begin
                            acc_hi <= rem_s;
                            acc_lo <= {acc_lo[XLEN-2:0], 1'b0};
                        end
                    end else
`endif
                    begin
                        {acc_hi, acc_lo} <= {carry, alu_result, acc_lo[XLEN-1:1]};
                    end
                end
                S_FIX: begin
                    bus.result <= word;
                    bus.done   <= 1'b1;
                    state      <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: vector table, corner sequences, random ops.
module tb_muldiv_seq;
    import muldiv_pkg::*;

    logic        clk;
    logic        rst;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_fun;
    logic [31:0] alu_result;

    int errors = 0;
    int checks = 0;

    muldiv_if bus();

    muldiv_seq dut (
        .CLK        (clk),
        .RST        (rst),
        .bus        (bus),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_fun    (alu_fun),
        .alu_result (alu_result)
    );

    assign alu_result = (alu_fun == ALU_SUB) ? alu_a - alu_b : alu_a + alu_b;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    function automatic bit div_en();
`ifdef MULDIV_DIV_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] ref_res(
        input logic [2:0] op, input logic [31:0] a, input logic [31:0] b
    );
        logic [63:0] sa, sb, ua, ub, p;
        int          ia, ib;
        bit          ovf;
        sa  = {{32{a[31]}}, a};
        sb  = {{32{b[31]}}, b};
        ua  = {32'd0, a};
        ub  = {32'd0, b};
        ia  = a;
        ib  = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        if (op[2] && !div_en()) return 32'd0;
        case (op)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(ia / ib);
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: return (b == 0) ? a : ovf ? 32'd0 : 32'(ia % ib);
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_lat(
        input logic [2:0] op, input logic [31:0] a, input logic [31:0] b
    );
        if (!op[2]) return 34;
        if (!div_en()) return 2;
        if (b == 0) return 2;
        if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return 2;
        return 34;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issues start at a negedge; lat counts edges after the sampling edge
    task automatic run_op(
        input  logic [2:0]  op,
        input  logic [31:0] a,
        input  logic [31:0] b,
        output logic [31:0] res,
        output int          lat
    );
        bit ok;
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        lat = 0;
        ok  = 1'b0;
        res = 'x;
        while (!ok && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
            if (bus.done) begin
                ok  = 1'b1;
                res = bus.result;
            end
        end
        check("done_timeout", 32'(ok), 32'd1);
    endtask

    vec_t        tbl[$];
    logic [31:0] res;
    int          lat;
    int          pulses;

    initial begin
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.op    = 3'd0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_result", bus.result, 32'd0);
        check("rst_alu_a", alu_a, 32'd0);
        check("rst_alu_b", alu_b, 32'd0);
        check("rst_alu_fun", 32'(alu_fun), 32'd0);
        rst = 1'b0;

        tbl.push_back('{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 34});
        tbl.push_back('{3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 34});
        tbl.push_back('{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 34});
        tbl.push_back('{3'd2, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, 34});
        tbl.push_back('{3'd5, 32'd100,        32'd7,         32'd14,        34});
        tbl.push_back('{3'd7, 32'd100,        32'd7,         32'd2,         34});
        tbl.push_back('{3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 34});
        tbl.push_back('{3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 34});
        tbl.push_back('{3'd4, 32'd5,          32'd0,         32'hFFFF_FFFF, 2});
        tbl.push_back('{3'd6, 32'd5,          32'd0,         32'd5,         2});
        tbl.push_back('{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 2});
        if (!div_en()) begin
            foreach (tbl[i]) begin
                if (tbl[i].op[2]) begin
                    tbl[i].exp = 32'd0;
                    tbl[i].lat = 2;
                end
            end
        end

        for (int i = 0; i < tbl.size(); i++) begin
            run_op(tbl[i].op, tbl[i].a, tbl[i].b, res, lat);
            check($sformatf("vec%0d_result", i), res, tbl[i].exp);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(tbl[i].lat));
            if (i == 0) begin
                check("busy_in_done", 32'(bus.busy), 32'd1);
                @(posedge clk);
                #1;
                check("busy_after_done", 32'(bus.busy), 32'd0);
                check("done_one_cycle", 32'(bus.done), 32'd0);
            end
        end

        // Reset in the middle of ITER
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = 3'd0;
        bus.a     = 32'd123;
        bus.b     = 32'd456;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (11) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_busy", 32'(bus.busy), 32'd0);
        check("midrst_done", 32'(bus.done), 32'd0);
        check("midrst_result", bus.result, 32'd0);
        rst    = 1'b0;
        pulses = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus.done) pulses++;
        end
        check("midrst_no_done", 32'(pulses), 32'd0);
        run_op(3'd0, 32'd3, 32'd4, res, lat);
        check("post_rst_mul", res, 32'd12);

        // start held high while busy, with operands changing underneath
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = 3'd0;
        bus.a     = 32'd5;
        bus.b     = 32'd6;
        @(posedge clk);
        #1;
        bus.a  = 32'd9;
        bus.b  = 32'd9;
        bus.op = 3'd3;
        lat    = 0;
        pulses = 0;
        while (pulses == 0 && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
            if (lat == 20) bus.start = 1'b0;
            if (bus.done) pulses++;
        end
        check("held_start_result", bus.result, 32'd30);
        check("held_start_latency", 32'(lat), 32'd34);

        // Back-to-back: second start issued while done is high
        run_op(3'd0, 32'd1000, 32'd1000, res, lat);
        check("b2b_first", res, 32'd1_000_000);
        run_op(3'd3, 32'h1234_5678, 32'h9ABC_DEF0, res, lat);
        check("b2b_second", res, ref_res(3'd3, 32'h1234_5678, 32'h9ABC_DEF0));
        check("b2b_latency", 32'(lat), 32'd34);

        for (int i = 0; i < 40; i++) begin
            logic [2:0]  op;
            logic [31:0] a, b;
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = 32'($urandom_range(1, 15));
                default: ;
            endcase
            run_op(op, a, b, res, lat);
            check($sformatf("rnd%0d_op%0d_result", i, op), res, ref_res(op, a, b));
            check($sformatf("rnd%0d_latency", i), 32'(lat), 32'(ref_lat(op, a, b)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
